// File: rtl/red_nibble_unpacker.sv
// Streams the four nibbles of a 16-bit word, each sign- or zero-extended,
// together with a running partial sum that ends at the word's nibble reduction.
module red_nibble_unpacker #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_word,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic [15:0] out_psum
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] acc_q, acc_d;

  logic [1:0]  sel;
  logic [3:0]  nib;
  logic [15:0] ext;

  // MSB-first order walks the nibbles downward: position 3-idx, i.e. ~idx.
  always_comb begin
    sel = LSB_FIRST ? idx_q : ~idx_q;
    case (sel)
      2'd0:    nib = word_q[3:0];
      2'd1:    nib = word_q[7:4];
      2'd2:    nib = word_q[11:8];
      default: nib = word_q[15:12];
    endcase
    ext = sgn_q ? {{12{nib[3]}}, nib} : {12'b0, nib};
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    sgn_d     = sgn_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_psum  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_word;
          sgn_d   = in_signed;
          idx_d   = '0;
          acc_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = ext;
        out_idx   = idx_q;
        out_last  = (idx_q == 2'd3);
        // acc_q holds the sum of beats already handed off.
        out_psum  = acc_q + ext;
        if (out_ready) begin
          acc_d = acc_q + ext;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      sgn_q   <= 1'b0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sgn_q   <= sgn_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_red_nibble_unpacker.sv
// Scoreboard bench: an LSB-first and an MSB-first unpacker share stimulus and
// are checked beat by beat against a nibble model.
module tb_red_nibble_unpacker;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
    logic [15:0] psum;
  } beat_t;

  typedef struct packed {
    beat_t lsb;
    beat_t msb;
  } pair_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_word;
  logic        in_signed;
  logic        out_ready;
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [15:0] out_data  [2];
  logic [1:0]  out_idx   [2];
  logic        out_last  [2];
  logic [15:0] out_psum  [2];

  int unsigned tests  = 0;
  int unsigned failed = 0;

  pair_t sbq[$];
  bit    prev_rst  = 1'b0;
  bit    exp_idle  = 1'b0;
  bit    exp_first = 1'b0;

  red_nibble_unpacker #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_word(in_word), .in_signed(in_signed), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_data(out_data[0]), .out_idx(out_idx[0]),
    .out_last(out_last[0]), .out_psum(out_psum[0])
  );

  red_nibble_unpacker #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_word(in_word), .in_signed(in_signed), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_data(out_data[1]), .out_idx(out_idx[1]),
    .out_last(out_last[1]), .out_psum(out_psum[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nib_val(input logic [15:0] w, input logic s, input int k, input bit lsb);
    int sh;
    int v;
    sh = lsb ? 4 * k : 12 - 4 * k;
    v  = int'((w >> sh) & 16'hF);
    if (s && v > 7) v -= 16;
    return v;
  endfunction

  function automatic beat_t model_beat(input logic [15:0] w, input logic s, input int k, input bit lsb);
    beat_t b;
    int acc;
    acc = 0;
    for (int j = 0; j <= k; j++) acc += nib_val(w, s, j, lsb);
    b.data = 16'(nib_val(w, s, k, lsb));
    b.idx  = 2'(k);
    b.last = (k == 3);
    b.psum = 16'(acc);
    return b;
  endfunction

  task automatic cmp_beat(input string who, input beat_t e, input logic [15:0] d,
                          input logic [1:0] i, input logic l, input logic [15:0] p);
    check({who, "_data"}, 32'(d), 32'(e.data));
    check({who, "_idx"},  32'(i), 32'(e.idx));
    check({who, "_last"}, 32'(l), 32'(e.last));
    check({who, "_psum"}, 32'(p), 32'(e.psum));
  endtask

  task automatic check_idle(input string who, input int u);
    check({who, "_in_ready"},  32'(in_ready[u]),  32'd1);
    check({who, "_out_valid"}, 32'(out_valid[u]), 32'd0);
    check({who, "_data0"},     32'(out_data[u]),  32'd0);
    check({who, "_psum0"},     32'(out_psum[u]),  32'd0);
    check({who, "_last0"},     32'(out_last[u]),  32'd0);
  endtask

  always @(negedge clk) begin
    pair_t p;
    if (prev_rst) begin
      check_idle("rst_lsb", 0);
      check_idle("rst_msb", 1);
      check("rst_idx", 32'({out_idx[0], out_idx[1]}), 32'd0);
    end
    prev_rst = rst;
    if (rst) begin
      sbq.delete();
      exp_idle  = 1'b0;
      exp_first = 1'b0;
    end else begin
      if (exp_idle) begin
        check("restart_ready", 32'({in_ready[0], in_ready[1]}), 32'h3);
        check("restart_novalid", 32'({out_valid[0], out_valid[1]}), 32'h0);
      end
      if (exp_first) begin
        check("first_valid", 32'({out_valid[0], out_valid[1]}), 32'h3);
        check("first_idx", 32'({out_idx[0], out_idx[1]}), 32'h0);
      end
      exp_idle  = 1'b0;
      exp_first = 1'b0;
      if (out_valid[0] || out_valid[1]) begin
        check("lockstep_valid", 32'(out_valid[1]), 32'(out_valid[0]));
        check("emit_not_ready", 32'({in_ready[0], in_ready[1]}), 32'h0);
        if (sbq.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          p = sbq[0];
          cmp_beat("lsb", p.lsb, out_data[0], out_idx[0], out_last[0], out_psum[0]);
          cmp_beat("msb", p.msb, out_data[1], out_idx[1], out_last[1], out_psum[1]);
          if (out_ready) begin
            void'(sbq.pop_front());
            if (p.lsb.last) exp_idle = 1'b1;
          end
        end
      end else begin
        check_idle("idle_lsb", 0);
        check_idle("idle_msb", 1);
        if (in_valid) begin
          for (int k = 0; k < 4; k++) begin
            p.lsb = model_beat(in_word, in_signed, k, 1'b1);
            p.msb = model_beat(in_word, in_signed, k, 1'b0);
            sbq.push_back(p);
          end
          exp_first = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [15:0] w, input logic s, input bit hold);
    int unsigned n;
    n = 0;
    in_word   = w;
    in_signed = s;
    in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready[0]) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    in_word   = 16'($urandom);
    in_signed = 1'($urandom);
  endtask

  task automatic wait_idle(input bit rnd);
    int unsigned n;
    n = 0;
    forever begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (!out_valid[0] && sbq.size() == 0) break;
      n++;
      if (n > 200) begin
        check("drain_timeout", 32'(n), 32'd0);
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(16'h1234, 1'b1, 1'b0); wait_idle(1'b0);
    send(16'hF8A7, 1'b1, 1'b0); wait_idle(1'b0);
    send(16'hF8A7, 1'b0, 1'b0); wait_idle(1'b0);
    send(16'h8888, 1'b1, 1'b0); wait_idle(1'b0);
    send(16'hFFFF, 1'b0, 1'b0); wait_idle(1'b0);

    // Stall beat 1 for three cycles.
    send(16'h5C3E, 1'b1, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle(1'b0);

    // Reset while beat 2 is presented.
    send(16'h9ABC, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle(1'b0);

    // Back-to-back words with in_valid held high throughout.
    send(16'h0F1E, 1'b1, 1'b1);
    send(16'h7F80, 1'b1, 1'b1);
    send(16'hA5C3, 1'b0, 1'b1);
    send(16'h8000, 1'b1, 1'b0);
    wait_idle(1'b0);

    for (int w = 0; w < 12; w++) begin
      send(16'($urandom), 1'($urandom), 1'b0);
      wait_idle(1'b1);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", failed);
    $fatal(1, "watchdog");
  end

endmodule
